// File: rtl/pp_seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// The block takes one multiplier bit per clock. After WIDTH accumulation
// cycles it loads the product register and raises done for one cycle.
// While RUN is active, start is ignored. In DONE, start is accepted, so
// operations can run back to back.
module pp_seq_multiplier #(
    parameter int WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [CW-1:0]    cnt;
    logic             last_step;

    // Multiplicand gated by multiplier bit idx, zero-extended to PW and
    // aligned to that bit's weight. The result is always below 2^PW, so the
    // accumulator never loses a carry.
    function automatic logic [PW-1:0] partial_product(
        input logic [WIDTH-1:0] mcand,
        input logic [WIDTH-1:0] mplier,
        input logic [CW-1:0]    idx
    );
        logic           bit_sel;
        logic [PW-1:0]  ext;
        bit_sel = ((mplier >> idx) & {{(WIDTH-1){1'b0}}, 1'b1}) != '0;
        ext     = {{WIDTH{1'b0}}, (mcand & {WIDTH{bit_sel}})};
        return ext << idx;
    endfunction

    // Next accumulator value and detection of the final (WIDTH-th) step
    always_comb begin
        acc_next  = acc + partial_product(a_lat, b_lat, cnt);
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM with registered busy/done and product load on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            cnt     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lat <= a;
                        b_lat <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pp_seq_multiplier.md
PP_SEQ_MULTIPLIER -- requirements
Module: pp_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, giving the operand width; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiplication.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid product.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: registered unsigned result of a*b.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL latch a and b, clear the 2*WIDTH accumulator, clear the bit counter, and enter RUN.
REQ-012 In RUN, each rising edge SHALL add partial product (a_latched AND {WIDTH{b_latched[cnt]}}) shifted left by cnt to the accumulator and increment cnt.
REQ-013 Accumulator arithmetic SHALL be 2*WIDTH bits wide and SHALL never overflow or truncate.
REQ-014 After exactly WIDTH accumulation edges, the FSM SHALL enter DONE and load product with the final accumulator value on the same edge.
REQ-015 Latency: start sampled at edge E0 SHALL give done=1 during the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after the start cycle.
REQ-016 busy SHALL be 1 exactly in RUN (WIDTH cycles per operation) and 0 in IDLE and DONE.
REQ-017 done SHALL be 1 exactly in DONE, lasting one cycle; without start, DONE SHALL return to IDLE.
REQ-018 start in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-019 start asserted during the DONE cycle SHALL be accepted (back-to-back operation); product SHALL hold the previous result until the new DONE.
REQ-020 product SHALL change only on entry to DONE or on reset, and SHALL otherwise hold its value indefinitely.
REQ-021 Changes on a and b after the start edge SHALL NOT affect the running operation.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, product=0, accumulator=0, counter=0, overriding start.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-025 The first start after rst deasserts SHALL be accepted at the first edge with rst=0.

Verification
REQ-026 WIDTH=28, a=3, b=5, pulse start -> busy high 28 cycles, done high for 1 cycle on cycle 29 after start, product=15.
REQ-027 WIDTH=28, a=b=0xFFFFFFF -> product=0xFFFFFFE0000001; a=0 or b=0 -> product=0 with the same latency.
REQ-028 Start a=7,b=9; at cycle 10 of RUN, pulse start with a=2,b=2 -> ignored; done once, product=63.
REQ-029 Hold start=1 continuously with a=4,b=6 -> done every 29 cycles, product=24, busy low only in DONE cycles.
REQ-030 Start a=100,b=100, assert rst at cycle 12 of RUN -> busy=0, product=0, no done; next start a=11,b=13 -> product=143.
REQ-031 WIDTH=8 instance, sweep all 65536 a,b pairs against the reference model a*b -> zero mismatches, done latency 9 cycles each.
